dm_cache: RTL and testbench

DM_CACHE -- requirements
Module: dm_cache

---
 rtl/dm_cache.sv | 146 ++++++++++++++
 tb/tb_dm_cache.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with one word per line.
// Define DM_CACHE_STATS_EN to add saturating read hit/miss counters (hit_cnt, miss_cnt).
module dm_cache #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFS_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFS_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic              flush_pend;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  q_idx;
    logic [TAG_W-1:0]  q_tag;
    logic              hit;
    logic              accept;
    logic              unused_ofs;

    assign req_idx    = req_addr[IDX_W+OFS_W-1:OFS_W];
    assign req_tag    = req_addr[ADDR_W-1:IDX_W+OFS_W];
    // mem_addr doubles as the registered request address for the whole transaction
    assign q_idx      = mem_addr[IDX_W+OFS_W-1:OFS_W];
    assign q_tag      = mem_addr[ADDR_W-1:IDX_W+OFS_W];
    assign unused_ofs = ^req_addr[OFS_W-1:0];

    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign req_ready = rst_n && (state == IDLE) && !flush && !flush_pend;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            flush_pend <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef DM_CACHE_STATS_EN
            hit_cnt    <= '0;
            miss_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            // A flush arriving mid-transaction is deferred until the FSM is back in IDLE
            if (flush && state != IDLE) begin
                flush_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end else if (accept) begin
                        mem_addr  <= req_addr;
                        mem_we    <= req_we;
                        mem_wdata <= req_wdata;
                        if (req_we) begin
                            mem_req <= 1'b1;
                            state   <= WR_THRU;
                        end else if (hit) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= data_mem[req_idx];
`ifdef DM_CACHE_STATS_EN
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
`endif
                        end else begin
                            mem_req <= 1'b1;
                            state   <= RD_MISS;
`ifdef DM_CACHE_STATS_EN
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
`endif
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        valid[q_idx] <= 1'b1;
                        mem_req      <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= mem_rdata;
                        state        <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid vector guards them
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && req_we && hit) begin
            data_mem[req_idx] <= req_wdata;
        end else if (state == RD_MISS && mem_ack) begin
            tag_mem[q_idx]  <= q_tag;
            data_mem[q_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache: a line-array model predicts every output cycle by cycle.
module tb_dm_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_we, req_ready, rsp_valid, flush;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
    logic [31:0] m_hits, m_misses;
`endif

    always #5 clk = ~clk;

    dm_cache dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DM_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    int total = 0;
    int bad = 0;

    logic        chk = 1'b0;
    logic        exp_ready, exp_rsp_valid, exp_mem_req, exp_mem_we;
    logic [31:0] exp_rdata, exp_mem_addr, exp_mem_wdata;

    bit          m_valid [128];
    logic [22:0] m_tag   [128];
    logic [31:0] m_data  [128];

    function automatic int ix(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    function automatic logic [22:0] tg(input logic [31:0] a);
        return a[31:9];
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 128; k++) m_valid[k] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("req_ready", req_ready, exp_ready);
            cmp("rsp_valid", rsp_valid, exp_rsp_valid);
            cmp("rsp_rdata", rsp_rdata, exp_rdata);
            cmp("mem_req", mem_req, exp_mem_req);
            if (exp_mem_req) begin
                cmp("mem_we", mem_we, exp_mem_we);
                cmp("mem_addr", mem_addr, exp_mem_addr);
                if (exp_mem_we) cmp("mem_wdata", mem_wdata, exp_mem_wdata);
            end
`ifdef DM_CACHE_STATS_EN
            cmp("hit_cnt", hit_cnt, m_hits);
            cmp("miss_cnt", miss_cnt, m_misses);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_rsp_valid = 1'b0;
        exp_rdata     = '0;
    endtask

    // Read: a hit responds the next cycle; a miss holds mem_req for dly cycles then refills
    task automatic rd(input logic [31:0] a, input logic [31:0] v, input int dly, input bit fl);
        bit h;
        h = m_valid[ix(a)] && (m_tag[ix(a)] == tg(a));
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0;
        exp_ready = 1'b1; exp_mem_req = 1'b0;
        step();
        req_valid = 1'b0;
        if (h) begin
`ifdef DM_CACHE_STATS_EN
            m_hits++;
`endif
            exp_rsp_valid = 1'b1;
            exp_rdata     = m_data[ix(a)];
        end else begin
`ifdef DM_CACHE_STATS_EN
            m_misses++;
`endif
            exp_ready = 1'b0; exp_mem_req = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = a;
            for (int k = 0; k < dly; k++) begin
                if (fl && k == 0) flush = 1'b1;
                step();
                flush = 1'b0;
            end
            mem_ack = 1'b1; mem_rdata = v;
            step();
            mem_ack = 1'b0; mem_rdata = '0;
            exp_mem_req = 1'b0; exp_rsp_valid = 1'b1; exp_rdata = v;
            m_valid[ix(a)] = 1'b1; m_tag[ix(a)] = tg(a); m_data[ix(a)] = v;
            if (fl) begin
                clear_model();
                exp_ready = 1'b0;
                step();
            end
            exp_ready = 1'b1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int dly);
        bit h;
        h = m_valid[ix(a)] && (m_tag[ix(a)] == tg(a));
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        exp_ready = 1'b1; exp_mem_req = 1'b0;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        if (h) m_data[ix(a)] = d;
        exp_ready = 1'b0; exp_mem_req = 1'b1; exp_mem_we = 1'b1;
        exp_mem_addr = a; exp_mem_wdata = d;
        repeat (dly) step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        exp_mem_req = 1'b0; exp_rsp_valid = 1'b1; exp_rdata = '0; exp_ready = 1'b1;
    endtask

    // Flush together with a request: flush wins and the request is dropped
    task automatic flush_idle(input logic [31:0] a);
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        exp_ready = 1'b0; exp_mem_req = 1'b0;
        step();
        flush = 1'b0; req_valid = 1'b0;
        clear_model();
        exp_ready = 1'b1;
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        exp_ready = 1'b0; exp_rsp_valid = 1'b0; exp_rdata = '0;
        exp_mem_req = 1'b0; exp_mem_we = 1'b0; exp_mem_addr = '0; exp_mem_wdata = '0;
        clear_model();
`ifdef DM_CACHE_STATS_EN
        m_hits = '0; m_misses = '0;
`endif
        chk = 1'b1;
        step();
        step();
        cmp("rst_mem_addr", mem_addr, 32'h0);
        cmp("rst_mem_wdata", mem_wdata, 32'h0);
        cmp("rst_mem_we", {31'd0, mem_we}, 32'h0);
        rst_n = 1'b1;
        exp_ready = 1'b1;
        step();

        rd(32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0);
        cmp("lit_refill_data", rsp_rdata, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'h0, 0, 1'b0);
        cmp("lit_hit_valid", {31'd0, rsp_valid}, 32'h1);
        cmp("lit_hit_data", rsp_rdata, 32'hDEAD_BEEF);
        cmp("lit_hit_no_mem", {31'd0, mem_req}, 32'h0);
        step();

        rd(32'h0000_0210, 32'hAAAA_5555, 1, 1'b0);
        rd(32'h0000_0010, 32'h0BAD_F00D, 0, 1'b0);
        cmp("lit_evict_refill", rsp_rdata, 32'h0BAD_F00D);

        wr(32'h0000_0010, 32'h1234_5678, 5);
        rd(32'h0000_0010, 32'h0, 0, 1'b0);
        cmp("lit_write_hit_data", rsp_rdata, 32'h1234_5678);
        wr(32'h0000_0040, 32'hCAFE_0001, 0);
        rd(32'h0000_0040, 32'h0000_0077, 1, 1'b0);
        cmp("lit_no_allocate", rsp_rdata, 32'h0000_0077);

        rd(32'h0000_0010, 32'h0, 0, 1'b0);
        rd(32'h0000_0040, 32'h0, 0, 1'b0);
        rd(32'h0000_0010, 32'h0, 0, 1'b0);

        flush_idle(32'h0000_0010);
        rd(32'h0000_0040, 32'h0000_0099, 1, 1'b0);

        rd(32'h0000_0080, 32'h5A5A_5A5A, 3, 1'b1);
        rd(32'h0000_0080, 32'h0000_0066, 0, 1'b0);
        rd(32'h0000_0040, 32'h0000_0042, 0, 1'b0);
        cmp("lit_after_pend_flush", rsp_rdata, 32'h0000_0042);

        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        step();

        rd(32'h0000_0010, 32'h0000_0011, 0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'h0000_5555;
        exp_ready = 1'b1; exp_mem_req = 1'b0;
        step();
        req_valid = 1'b0; req_we = 1'b0;
        exp_ready = 1'b0; exp_mem_req = 1'b1; exp_mem_we = 1'b1;
        exp_mem_addr = 32'h0000_0010; exp_mem_wdata = 32'h0000_5555;
        step();
        rst_n = 1'b0;
        #1;
        cmp("rst_async_mem_req", {31'd0, mem_req}, 32'h0);
        cmp("rst_async_ready", {31'd0, req_ready}, 32'h0);
        exp_mem_req = 1'b0; exp_ready = 1'b0;
        clear_model();
`ifdef DM_CACHE_STATS_EN
        m_hits = '0; m_misses = '0;
`endif
        step();
        step();
        rst_n = 1'b1;
        exp_ready = 1'b1;
        step();
        rd(32'h0000_0010, 32'h0000_0033, 1, 1'b0);
        cmp("lit_miss_after_reset", rsp_rdata, 32'h0000_0033);
        step();
        chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
